// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the core-to-bus data memory bridge.
// Size codes follow the core's Bit_S field; code 3 is handled as a word.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store data replicated across byte lanes,
// load data pulled from its lane and left-justified for the core.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  wr_size,
  input  logic [31:0] wdata,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_lo,
  input  logic [31:0] rdata,
  output logic [31:0] wlane,
  output logic [31:0] rlane
);

  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][7:0] wl;
  logic [NUM_LANES-1:0][7:0] rb;

  assign rb    = rdata;
  assign wlane = wl;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_wlane
    assign wl[i] = (wr_size == SZ_BYTE) ? wdata[7:0] :
                   (wr_size == SZ_HALF) ? wdata[8*(i%2) +: 8] :
                                          wdata[8*i +: 8];
  end

  always_comb begin
    rlane = rdata;
    case (rd_size)
      SZ_BYTE: rlane = {rb[rd_lo], 24'b0};
      SZ_HALF: rlane = {(rd_lo[1] ? rdata[31:16] : rdata[15:0]), 16'b0};
      default: rlane = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Adapts the core's byte/half/word data port to a word-wide ready/ack bus,
// stalling the core while a transaction is outstanding.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cs,
  input  logic        cpu_w,
  input  logic        cpu_r,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_size,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             err_q, ld_q;
  logic [1:0]       sz_q, lo_q;
  logic [31:0]      wlane, rlane;
  logic             misal, tmo;

  assign misal     = is_misaligned(cpu_size, cpu_addr[1:0]);
  assign tmo       = (cnt == CNT_W'(TIMEOUT - 1));
  assign cpu_stall = cpu_cs && (state != ST_DONE);
  assign cpu_err   = (state == ST_DONE) && err_q;

  // Write side steers the live request; read side uses the latched request
  // because the data only arrives with the ack.
  dmem_lane_align u_lane (
    .wr_size (cpu_size),
    .wdata   (cpu_wdata),
    .rd_size (sz_q),
    .rd_lo   (lo_q),
    .rdata   (bus_rdata),
    .wlane   (wlane),
    .rlane   (rlane)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (cpu_cs) state_nx = misal ? ST_DONE : ST_WAIT;
      ST_WAIT: if (bus_ack || tmo) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      cpu_rdata <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
      ld_q      <= 1'b0;
      sz_q      <= SZ_WORD;
      lo_q      <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt   <= '0;
          err_q <= 1'b0;
          if (cpu_cs) begin
            if (misal) begin
              err_q     <= 1'b1;
              cpu_rdata <= '0;
            end else begin
              // A store wins when both strobes are raised.
              bus_req   <= 1'b1;
              bus_we    <= cpu_w;
              bus_addr  <= {cpu_addr[31:2], 2'b00};
              bus_be    <= byte_en(cpu_size, cpu_addr[1:0]);
              bus_wdata <= wlane;
              ld_q      <= cpu_r && !cpu_w;
              sz_q      <= cpu_size;
              lo_q      <= cpu_addr[1:0];
            end
          end
        end
        ST_WAIT: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (ld_q) cpu_rdata <= rlane;
          end else if (tmo) begin
            bus_req   <= 1'b0;
            err_q     <= 1'b1;
            cpu_rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          cnt   <= '0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench: vector table through a cycle-level slave, scoreboard
// of expected load data/err, plus reset-mid-transaction and back-to-back cases.
module tb_dmem_bridge;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_cs, cpu_w, cpu_r;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [1:0]  cpu_size;
  logic        cpu_stall, cpu_err;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  dmem_bridge #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_cs(cpu_cs), .cpu_w(cpu_w), .cpu_r(cpu_r),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_size(cpu_size),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  typedef struct {
    logic        w;
    logic        r;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;   // ack on WAIT cycle delay+1; negative = never
    logic [3:0]  be;
    logic [31:0] bwd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          reqc;
    int          stallc;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int delay,
                              input logic [3:0] be, input logic [31:0] bwd,
                              input logic [31:0] exp_rd, input logic exp_err,
                              input int reqc, input int stallc);
    vec_t v;
    v.w = w; v.r = r; v.size = size; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.delay = delay; v.be = be; v.bwd = bwd;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.reqc = reqc; v.stallc = stallc;
    return v;
  endfunction

  // Starts on a negedge with the DUT in IDLE; returns on a negedge.
  task automatic access(input vec_t v, input bit keep);
    int          stall_n = 0;
    int          req_n = 0;
    bit          done = 0;
    bit          stable = 1;
    logic [31:0] a0 = '0, wd0 = '0;
    logic [3:0]  be0 = '0;
    logic        we0 = 1'b0;
    exp_t        e;
    sb.push_back('{rd: v.exp_rd, err: v.exp_err});
    cpu_cs = 1'b1; cpu_w = v.w; cpu_r = v.r; cpu_size = v.size;
    cpu_addr = v.addr; cpu_wdata = v.wdata; bus_rdata = v.rdata; bus_ack = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      #1;
      if (!cpu_stall) begin
        done = 1;
        break;
      end
      stall_n++;
      if (bus_req) begin
        req_n++;
        if (req_n == 1) begin
          a0 = bus_addr; be0 = bus_be; wd0 = bus_wdata; we0 = bus_we;
        end else if (bus_addr !== a0 || bus_be !== be0 || bus_wdata !== wd0 || bus_we !== we0) begin
          stable = 0;
        end
        bus_ack = (v.delay >= 0) && (req_n == v.delay + 1);
      end else begin
        bus_ack = 1'b0;
      end
      @(negedge clk);
    end
    e = sb.pop_front();
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: no DONE within 64 cycles at addr %h", v.addr);
    end else begin
      chk("rdata", cpu_rdata, e.rd);
      chk("err", {31'b0, cpu_err}, {31'b0, e.err});
      chk("req_in_done", {31'b0, bus_req}, 32'd0);
    end
    chk("stall_cycles", stall_n, v.stallc);
    chk("req_cycles", req_n, v.reqc);
    if (v.reqc > 0) begin
      chk("bus_addr", a0, {v.addr[31:2], 2'b00});
      chk("bus_be", {28'b0, be0}, {28'b0, v.be});
      chk("bus_wdata", wd0, v.bwd);
      chk("bus_we", {31'b0, we0}, {31'b0, v.w});
      chk("bus_stable", {31'b0, stable}, 32'd1);
    end
    bus_ack = 1'b0;
    if (!keep) cpu_cs = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    cpu_cs = 0; cpu_w = 0; cpu_r = 0; cpu_addr = '0; cpu_wdata = '0; cpu_size = '0;
    bus_rdata = '0; bus_ack = 0;

    //             w  r  sz  addr          wdata         rdata         dly be       bwd           exp_rd        err reqc stall
    vecs[0]  = mk(1, 0, 2, 32'h0000_0010, 32'h1122_3344, 32'h0,         0, 4'b1111, 32'h1122_3344, 32'h0000_0000, 0, 1, 2);
    vecs[1]  = mk(0, 1, 0, 32'h0000_0013, 32'h0,         32'hAABB_CCDD, 0, 4'b1000, 32'h0,         32'hAA00_0000, 0, 1, 2);
    vecs[2]  = mk(1, 0, 1, 32'h0000_0022, 32'h0000_BEEF, 32'h0,         3, 4'b1100, 32'hBEEF_BEEF, 32'hAA00_0000, 0, 4, 5);
    vecs[3]  = mk(0, 1, 2, 32'h0000_0001, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         32'h0000_0000, 1, 0, 1);
    vecs[4]  = mk(0, 1, 1, 32'h0000_0003, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         32'h0000_0000, 1, 0, 1);
    vecs[5]  = mk(0, 1, 1, 32'h0000_0006, 32'h0,         32'h1234_5678, 1, 4'b1100, 32'h0,         32'h1234_0000, 0, 2, 3);
    vecs[6]  = mk(0, 1, 0, 32'h0000_0001, 32'h0,         32'h1234_5678, 0, 4'b0010, 32'h0,         32'h5600_0000, 0, 1, 2);
    vecs[7]  = mk(0, 1, 2, 32'h0000_0008, 32'h0,         32'hCAFE_F00D, 2, 4'b1111, 32'h0,         32'hCAFE_F00D, 0, 3, 4);
    vecs[8]  = mk(0, 1, 2, 32'h0000_0040, 32'h0,         32'hDEAD_DEAD,-1, 4'b1111, 32'h0,         32'h0000_0000, 1, 4, 5);
    vecs[9]  = mk(0, 1, 2, 32'h0000_0044, 32'h0,         32'h0BAD_BEEF, 3, 4'b1111, 32'h0,         32'h0BAD_BEEF, 0, 4, 5);
    vecs[10] = mk(1, 0, 0, 32'h0000_0005, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0BAD_BEEF, 0, 1, 2);
    vecs[11] = mk(1, 0, 3, 32'h0000_000C, 32'h0102_0304, 32'h0,         0, 4'b1111, 32'h0102_0304, 32'h0BAD_BEEF, 0, 1, 2);
    vecs[12] = mk(1, 1, 0, 32'h0000_0002, 32'h0000_0077, 32'h1111_1111, 0, 4'b0100, 32'h7777_7777, 32'h0BAD_BEEF, 0, 1, 2);
    vecs[13] = mk(0, 1, 1, 32'h0000_0000, 32'h0,         32'h89AB_CDEF, 0, 4'b0011, 32'h0,         32'hCDEF_0000, 0, 1, 2);

    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, bus_req}, 32'd0);
    chk("rst_we", {31'b0, bus_we}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_be", {28'b0, bus_be}, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_err", {31'b0, cpu_err}, 32'd0);
    chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Stray ack while idle must not start anything.
    bus_ack = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_ack_req", {31'b0, bus_req}, 32'd0);
    chk("idle_ack_stall", {31'b0, cpu_stall}, 32'd0);
    bus_ack = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) access(vecs[i], 1'b0);

    // Reset asserted mid-WAIT, away from any clock edge.
    cpu_cs = 1; cpu_w = 0; cpu_r = 1; cpu_size = 2; cpu_addr = 32'h0000_0100;
    cpu_wdata = 32'h0; bus_rdata = 32'h1234_4321; bus_ack = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("wait_req", {31'b0, bus_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", {31'b0, bus_req}, 32'd0);
    chk("arst_we", {31'b0, bus_we}, 32'd0);
    chk("arst_addr", bus_addr, 32'd0);
    chk("arst_be", {28'b0, bus_be}, 32'd0);
    chk("arst_wdata", bus_wdata, 32'd0);
    chk("arst_rdata", cpu_rdata, 32'd0);
    chk("arst_err", {31'b0, cpu_err}, 32'd0);
    cpu_cs = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back load then store with cs held through DONE.
    access(mk(0, 1, 2, 32'h0000_0020, 32'h0, 32'h55AA_55AA, 0, 4'b1111, 32'h0,
              32'h55AA_55AA, 0, 1, 2), 1'b1);
    access(mk(1, 0, 1, 32'h0000_0020, 32'h0000_1234, 32'h0, 0, 4'b0011, 32'h1234_1234,
              32'h55AA_55AA, 0, 1, 2), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Data-memory port adapter that sits directly downstream of the CPU_54 core's data port (DM_CS/DM_W/DM_R/ALUR_to_DM/Rt_to_DM/Bit_S) and upstream of a word-wide, ready/ack-handshaked memory bus.
- Converts byte/half/word accesses into word-aligned bus transactions with byte enables.
- Returns load data aligned the way the core consumes it: byte in [31:24], half in [31:16].
- Stalls the core while a transaction is outstanding; flags misalignment and bus timeout.

Parameters:
- TIMEOUT, 16: maximum cycles in WAIT without bus_ack before the access is aborted (must be at least 1).
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_cs  in  1  data access request (DM_CS).
- cpu_w  in  1  store (DM_W).
- cpu_r  in  1  load (DM_R).
- cpu_addr  in  32  byte address (ALUR_to_DM).
- cpu_wdata  in  32  store data, right-justified (Rt_to_DM).
- cpu_size  in  2  access size: 0 byte, 1 half, 2 word (Bit_S); 3 is treated as word.
- cpu_rdata  out  32  aligned load data.
- cpu_stall  out  1  core must hold PC and its request while high.
- cpu_err  out  1  one-cycle pulse in DONE if the access was misaligned or timed out.
- bus_req  out  1  transaction request.
- bus_we  out  1  write strobe.
- bus_addr  out  32  word address {cpu_addr[31:2],2'b00}.
- bus_be  out  4  byte enables, little-endian lanes (be[0] = bits 7:0).
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read data, valid with bus_ack.
- bus_ack  in  1  transaction complete.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, cpu_rdata=0, cpu_err=0, timeout counter=0. A reset mid-transaction drops bus_req immediately, without waiting for a clock edge.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If cpu_cs=1 and the access is aligned: latch all bus outputs and go to WAIT, with bus_req=1 registered.
  - If cpu_cs=1 and the access is misaligned: go to DONE with err set. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0. No bus transaction is issued, and rdata=0.
- Byte enables:
  - Byte: be = 1<<addr[1:0].
  - Half: be = addr[1] ? 4'b1100 : 4'b0011.
  - Word: be = 4'b1111.
- Store data:
  - Byte: bus_wdata = {4{wdata[7:0]}}.
  - Half: bus_wdata = {2{wdata[15:0]}}.
  - Word: bus_wdata = wdata unchanged.
- WAIT:
  - bus_req, bus_we, bus_addr, bus_be and bus_wdata are held stable.
  - On bus_ack=1: capture the aligned read data (loads only), drop bus_req next edge, go to DONE.
  - Read alignment, byte: rdata = {lane byte, 24'b0}.
  - Read alignment, half: rdata = {selected halfword, 16'b0}.
  - Read alignment, word: rdata = bus_rdata.
  - Stores leave cpu_rdata unchanged.
  - The counter increments each WAIT cycle without ack. When it reaches TIMEOUT: drop bus_req, set err, rdata=0, go to DONE.
  - An ack in the same cycle as the timeout wins: normal completion, no err.
- DONE:
  - cpu_stall=0 and cpu_err reflects the latched flag, both for exactly one cycle.
  - Unconditionally return to IDLE; the counter and err are cleared.
  - The core retires the instruction at this edge.
- cpu_stall is combinational: cpu_cs && state≠DONE.
- Latency with a zero-wait slave (ack in the first WAIT cycle): cs seen at t0, WAIT at t1, DONE at t2. Stall is high at t0 and t1, low at t2. Each extra wait cycle adds one stall cycle.
- Back-to-back accesses: a request present in IDLE the cycle after DONE is accepted normally. There is no bubble beyond the IDLE cycle.
- cpu_cs=0 in IDLE: no state change, stall=0.
- cpu_w and cpu_r are mutually exclusive. If both are 1, treat the access as a store.
- bus_ack in IDLE or DONE is ignored.
- cpu_rdata holds its last value between loads.

Decomposition:
- Shared package dmem_pkg holds:
  - the size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2;
  - the state encodings;
  - alignment-check and byte-enable generator functions.
- One natural sub-module, dmem_lane_align: purely combinational read-lane extraction and write-lane replication, instantiated once. Implementing and verifying it separately keeps the FSM small.

Test Plan:
- Word store, addr=0x0000_0010, wdata=0x1122_3344, slave acks on the first WAIT cycle → bus_we=1, be=4'b1111, bus_addr=0x10, bus_wdata=0x11223344; stall high 2 cycles; err=0.
- Byte load, addr=0x0000_0013, bus_rdata=0xAABB_CCDD → be=4'b1000; cpu_rdata=0xAA00_0000 in DONE.
- Half store, addr=0x22, wdata=0x0000_BEEF, ack delayed 3 cycles → bus_wdata=0xBEEF_BEEF, be=4'b1100; bus outputs stable throughout WAIT; stall high 5 cycles.
- Word load at addr=0x1, then half at addr=0x3 → no bus_req; DONE after 1 stall cycle; cpu_err pulse; cpu_rdata=0.
- TIMEOUT=4, slave never acks → bus_req high exactly 4 cycles, then DONE with err=1 and rdata=0.
- Same setup with ack on the 4th cycle → normal completion, err=0.
- rst asserted low mid-WAIT → bus_req drops asynchronously; all outputs return to reset values.
- After rst is released, a back-to-back load/store pair completes correctly.
